pll_clkdiv_mc: RTL and testbench

- Multi-channel digital clock generator for the FM radio fabric. It sits downstream of the fixed-ratio PLL wrapper and runs on its output clock.
- Generates NUM_CH divided clocks, each with a runtime-programmable integer divisor and phase offset. Every channel also produces a one-cycle rising-edge strobe.
- Adds a lock sequencer and a DRP-style reconfiguration port that the fixed PLL wrapper does not provide.

---
 rtl/pll_clkdiv_mc.sv | 115 +++++++++++
 tb/tb_pll_clkdiv_mc.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pll_clkdiv_mc.sv
// rtl/pll_clkdiv_mc.sv - multi-channel integer clock divider with lock sequencer and DRP reconfiguration
module pll_clkdiv_mc #(
   parameter int NUM_CH      = 4,
   parameter int DIV_W       = 8,
   parameter int DIV_DEFAULT = 5,
   parameter int LOCK_CYCLES = 16
) (
   input  logic                 refclk,
   input  logic                 rst_n,
   input  logic                 pllreset,
   input  logic [NUM_CH-1:0]    clk_en,
   input  logic                 drp_wr,
   input  logic [2:0]           drp_addr,
   input  logic [2*DIV_W-1:0]   drp_wdata,
   output logic                 drp_rdy,
   output logic                 drp_err,
   output logic [NUM_CH-1:0]    clk_out,
   output logic [NUM_CH-1:0]    clk_stb,
   output logic                 lock
);

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_ALIGN     = 2'd1;
   localparam logic [1:0] ST_WAIT_LOCK = 2'd2;
   localparam logic [1:0] ST_LOCKED    = 2'd3;
   localparam int LCW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

   logic [1:0]       state;
   logic [LCW-1:0]   lock_cnt;
   logic [DIV_W-1:0] div_r   [NUM_CH];
   logic [DIV_W-1:0] phase_r [NUM_CH];
   logic [DIV_W-1:0] cnt     [NUM_CH];

   logic             running;
   logic [DIV_W-1:0] wr_div;
   logic [DIV_W-1:0] wr_phase;
   logic             addr_ok;
   logic             wr_valid;
   logic             wr_take;
   logic             wr_accept;
   logic             wr_reject;

   assign running   = (state == ST_WAIT_LOCK) || (state == ST_LOCKED);
   assign drp_rdy   = running;
   assign lock      = (state == ST_LOCKED);
   assign wr_div    = drp_wdata[DIV_W-1:0];
   assign wr_phase  = drp_wdata[2*DIV_W-1:DIV_W];
   assign addr_ok   = (32'(drp_addr) < NUM_CH);
   assign wr_valid  = addr_ok && (wr_div > DIV_W'(1)) && (wr_phase < wr_div);
   // pllreset outranks a same-cycle write: it is neither applied nor flagged
   assign wr_take   = drp_wr && running && !pllreset;
   assign wr_accept = wr_take && wr_valid;
   assign wr_reject = wr_take && !wr_valid;

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         lock_cnt <= '0;
         drp_err  <= 1'b0;
      end else begin
         drp_err <= wr_reject;
         if (pllreset) begin
            state <= ST_IDLE;
         end else begin
            case (state)
               ST_IDLE: state <= ST_ALIGN;
               ST_ALIGN: begin
                  state    <= ST_WAIT_LOCK;
                  lock_cnt <= '0;
               end
               ST_WAIT_LOCK: begin
                  if (wr_accept)
                     state <= ST_ALIGN;
                  else if (lock_cnt == LCW'(LOCK_CYCLES - 1))
                     state <= ST_LOCKED;
                  else
                     lock_cnt <= lock_cnt + LCW'(1);
               end
               default: begin
                  if (wr_accept)
                     state <= ST_ALIGN;
               end
            endcase
         end
      end
   end

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         clk_out <= '0;
         clk_stb <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            div_r[i]   <= DIV_W'(DIV_DEFAULT);
            phase_r[i] <= '0;
            cnt[i]     <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (wr_accept && (drp_addr == 3'(i))) begin
               div_r[i]   <= wr_div;
               phase_r[i] <= wr_phase;
            end
            if (state == ST_ALIGN)
               cnt[i] <= phase_r[i];
            else if (running)
               cnt[i] <= (cnt[i] == div_r[i] - DIV_W'(1)) ? '0 : cnt[i] + DIV_W'(1);
            // high phase is ceil(div/2) so odd divisors give the extra cycle to high
            clk_out[i] <= running && !pllreset && clk_en[i] &&
                          ({1'b0, cnt[i]} < (({1'b0, div_r[i]} + {{DIV_W{1'b0}}, 1'b1}) >> 1));
            clk_stb[i] <= running && !pllreset && clk_en[i] && (cnt[i] == '0);
         end
      end
   end

endmodule

// File: tb/tb_pll_clkdiv_mc.sv
// tb/tb_pll_clkdiv_mc.sv - randomized bench for pll_clkdiv_mc against a timeline reference model
module tb_pll_clkdiv_mc;

   localparam int NUM_CH      = 4;
   localparam int DIV_W       = 8;
   localparam int DIV_DEFAULT = 5;
   localparam int LOCK_CYCLES = 16;

   logic                refclk = 1'b0;
   logic                rst_n;
   logic                pllreset;
   logic [NUM_CH-1:0]   clk_en;
   logic                drp_wr;
   logic [2:0]          drp_addr;
   logic [2*DIV_W-1:0]  drp_wdata;
   logic                drp_rdy;
   logic                drp_err;
   logic [NUM_CH-1:0]   clk_out;
   logic [NUM_CH-1:0]   clk_stb;
   logic                lock;

   int checks   = 0;
   int failures = 0;

   // model: edges elapsed, edge at which ALIGN was entered, idle flag, per-channel config
   int n      = 0;
   int a_edge = 0;
   bit m_idle = 1;
   int div_m [NUM_CH];
   int ph_m  [NUM_CH];

   pll_clkdiv_mc #(
      .NUM_CH(NUM_CH), .DIV_W(DIV_W), .DIV_DEFAULT(DIV_DEFAULT), .LOCK_CYCLES(LOCK_CYCLES)
   ) dut (
      .refclk(refclk), .rst_n(rst_n), .pllreset(pllreset), .clk_en(clk_en),
      .drp_wr(drp_wr), .drp_addr(drp_addr), .drp_wdata(drp_wdata),
      .drp_rdy(drp_rdy), .drp_err(drp_err), .clk_out(clk_out), .clk_stb(clk_stb), .lock(lock)
   );

   always #5 refclk = ~refclk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_idle = 1;
      for (int i = 0; i < NUM_CH; i++) begin
         div_m[i] = DIV_DEFAULT;
         ph_m[i]  = 0;
      end
   endtask

   task automatic step();
      logic [NUM_CH-1:0] eo, es;
      logic ee, el, er;
      int e, pos, wdv, wph;
      bit run, bad, acc;
      e   = n - a_edge;
      run = !m_idle && (e >= 1);
      eo  = '0;
      es  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (run) begin
            pos   = (ph_m[i] + e - 1) % div_m[i];
            eo[i] = !pllreset && clk_en[i] && (pos < (div_m[i] + 1) / 2);
            es[i] = !pllreset && clk_en[i] && (pos == 0);
         end
      end
      wdv = int'(drp_wdata[DIV_W-1:0]);
      wph = int'(drp_wdata[2*DIV_W-1:DIV_W]);
      bad = (int'(drp_addr) >= NUM_CH) || (wdv < 2) || (wph >= wdv);
      acc = run && drp_wr && !pllreset && !bad;
      ee  = run && drp_wr && !pllreset && bad;
      n++;
      if (pllreset) m_idle = 1;
      else if (m_idle) begin
         m_idle = 0;
         a_edge = n;
      end else if (acc) begin
         div_m[drp_addr] = wdv;
         ph_m[drp_addr]  = wph;
         a_edge = n;
      end
      el = !m_idle && (n - a_edge) >= LOCK_CYCLES + 1;
      er = !m_idle && (n - a_edge) >= 1;
      @(posedge refclk);
      #1;
      chk("clk_out", 32'(clk_out), 32'(eo));
      chk("clk_stb", 32'(clk_stb), 32'(es));
      chk("lock", 32'(lock), 32'(el));
      chk("drp_rdy", 32'(drp_rdy), 32'(er));
      chk("drp_err", 32'(drp_err), 32'(ee));
   endtask

   task automatic drp(input int addr, input int ph, input int dv);
      drp_wr    = 1'b1;
      drp_addr  = addr[2:0];
      drp_wdata = {ph[DIV_W-1:0], dv[DIV_W-1:0]};
      step();
      drp_wr    = 1'b0;
   endtask

   task automatic run_cycles(input int k);
      for (int j = 0; j < k; j++) step();
   endtask

   initial begin
      int k, k0, k1;
      rst_n = 1'b0; pllreset = 1'b0; clk_en = '1;
      drp_wr = 1'b0; drp_addr = '0; drp_wdata = '0;
      model_reset();
      #12;
      chk("rst_clk_out", 32'(clk_out), 0);
      chk("rst_lock", 32'(lock), 0);
      chk("rst_rdy", 32'(drp_rdy), 0);
      @(negedge refclk);
      rst_n = 1'b1;

      // release -> ALIGN on first edge, then one ALIGN cycle plus LOCK_CYCLES in WAIT_LOCK
      k = 0;
      for (int j = 1; j <= 40 && k == 0; j++) begin
         step();
         if (lock) k = j;
      end
      chk("lock_latency", 32'(k), 32'(2 + LOCK_CYCLES));
      run_cycles(20);

      drp(1, 2, 8);
      k0 = 0; k1 = 0;
      for (int j = 1; j <= 40; j++) begin
         step();
         if (clk_stb[0] && k0 == 0) k0 = j;
         if (clk_stb[1] && k1 == 0) k1 = j;
      end
      chk("ch1_trail", 32'(k1 - k0), 32'd6);
      chk("ch1_seen", 32'(k0 != 0 && k1 != 0), 32'd1);

      drp(0, 0, 1);  run_cycles(3);
      drp(2, 5, 5);  run_cycles(3);
      drp(4, 0, 5);  run_cycles(10);

      clk_en[2] = 1'b0; run_cycles(7);
      clk_en[2] = 1'b1; run_cycles(15);

      pllreset = 1'b1;
      drp(3, 1, 9);
      run_cycles(2);
      pllreset = 1'b0;
      run_cycles(30);

      drp(3, 0, 12);
      run_cycles(5);
      #2 rst_n = 1'b0;
      #1;
      chk("async_clk_out", 32'(clk_out), 0);
      chk("async_clk_stb", 32'(clk_stb), 0);
      chk("async_lock", 32'(lock), 0);
      model_reset();
      @(posedge refclk);
      @(negedge refclk);
      rst_n = 1'b1;
      run_cycles(40);

      for (int j = 0; j < 1500; j++) begin
         pllreset = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 7) == 0) clk_en = NUM_CH'($urandom);
         if ($urandom_range(0, 9) == 0) begin
            drp_wr    = 1'b1;
            drp_addr  = 3'($urandom_range(0, 7));
            drp_wdata = {8'($urandom_range(0, 12)), 8'($urandom_range(0, 12))};
         end
         step();
         drp_wr = 1'b0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
